// File: rtl/ddp_fp_pkg.sv
// Shared definitions for the FP issue path: opcodes, packet field positions
// and the arbiter state encoding.
package ddp_fp_pkg;

    localparam logic [5:0] OPC_ADD    = 6'b000000;
    localparam logic [5:0] OPC_SUB    = 6'b000001;
    localparam logic [5:0] OPC_MUL    = 6'b000010;
    localparam logic [5:0] OPC_CMP    = 6'b000011;
    localparam logic [5:0] OPC_ABSORB = 6'b111111;

    localparam int OPC_LSB_DEF = 34;
    localparam int OPC_W       = 6;
    localparam int DATAL_MSB   = 31;
    localparam int DATAL_LSB   = 16;
    localparam int DATAR_MSB   = 15;
    localparam int DATAR_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic opc_is_absorb(input logic [OPC_W-1:0] opc);
        return opc == OPC_ABSORB;
    endfunction

endpackage

// File: rtl/fp_issue_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the channel
// that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       vld
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);
    assign vld    = |req;

endmodule

// File: rtl/fp_issue_arbiter.sv
// Shares one FP stage between two packet sources with round-robin capture,
// a Send/Ack handshake toward the FP, and local consumption of ABSORB packets.
module fp_issue_arbiter
    import ddp_fp_pkg::*;
#(
    parameter int PKT_W        = 62,
    parameter int OPC_LSB      = OPC_LSB_DEF,
    parameter int CNT_W        = 16,
    parameter int ABSORB_LOCAL = 1
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             Send_in0,
    input  logic [PKT_W-1:0] PACKET_IN0,
    input  logic             Send_in1,
    input  logic [PKT_W-1:0] PACKET_IN1,
    output logic             Ack_out0,
    output logic             Ack_out1,
    output logic             Send_out,
    output logic [PKT_W-1:0] PACKET_OUT,
    input  logic             Ack_in,
    output logic             BUSY,
    output logic [CNT_W-1:0] GRANT_CNT0,
    output logic [CNT_W-1:0] GRANT_CNT1,
    output logic [CNT_W-1:0] ABSORB_CNT
);

    state_e           state;
    logic             last;
    logic [1:0]       ack_q;
    logic [PKT_W-1:0] pkt_q;
    logic [CNT_W-1:0] gcnt0, gcnt1, acnt;

    logic [1:0]       gnt;
    logic             vld;
    logic [PKT_W-1:0] sel_pkt;
    logic [OPC_W-1:0] sel_opc;
    logic             absorb;

    rr_arb2 u_rr (
        .req  ({Send_in1, Send_in0}),
        .last (last),
        .gnt  (gnt),
        .vld  (vld)
    );

    assign sel_pkt = gnt[1] ? PACKET_IN1 : PACKET_IN0;
    assign sel_opc = sel_pkt[OPC_LSB +: OPC_W];
    assign absorb  = (ABSORB_LOCAL != 0) && opc_is_absorb(sel_opc);

    // Absorbed packets never load pkt_q, so PACKET_OUT keeps the last
    // issued packet while the arbiter is outside ISSUE.
    always_ff @(posedge CLK) begin
        if (MR) begin
            state <= IDLE;
            last  <= 1'b1;
            ack_q <= 2'b00;
            pkt_q <= '0;
            gcnt0 <= '0;
            gcnt1 <= '0;
            acnt  <= '0;
        end else begin
            ack_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (vld) begin
                        ack_q <= gnt;
                        last  <= gnt[1];
                        if (gnt[0]) gcnt0 <= gcnt0 + 1'b1;
                        else        gcnt1 <= gcnt1 + 1'b1;
                        if (absorb) begin
                            state <= HOLD;
                            acnt  <= acnt + 1'b1;
                        end else begin
                            state <= ISSUE;
                            pkt_q <= sel_pkt;
                        end
                    end
                end
                ISSUE: if (Ack_in) state <= IDLE;
                HOLD:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Ack_out0   = ack_q[0];
    assign Ack_out1   = ack_q[1];
    assign Send_out   = (state == ISSUE);
    assign BUSY       = (state != IDLE);
    assign PACKET_OUT = pkt_q;
    assign GRANT_CNT0 = gcnt0;
    assign GRANT_CNT1 = gcnt1;
    assign ABSORB_CNT = acnt;

endmodule
